// File: rtl/demux4_stream.sv
// 1->4 valid/ready stream demultiplexer with a one-entry holding register per channel.
// Optional per-channel drain counters (cnt0..cnt3) are built when DEMUX4_STREAM_CNT_EN is defined.

// Per-channel state (full flag):
//   state | meaning
//   EMPTY | out_valid[i]=0, channel can take a beat
//   FULL  | out_valid[i]=1, out_data_i holds a beat for consumer i
module demux4_stream #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        sel,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3
`ifdef DEMUX4_STREAM_CNT_EN
    ,
    output logic [7:0]        cnt0,
    output logic [7:0]        cnt1,
    output logic [7:0]        cnt2,
    output logic [7:0]        cnt3
`endif
);

    logic [3:0]        full_q;
    logic [DATA_W-1:0] data_q [4];
    logic [3:0]        drain;
    logic [3:0]        load;
    logic              accept;

    // Ready depends only on the addressed channel, so a stalled channel
    // blocks the producer only while sel points at it.
    assign in_ready = rst_n & (~full_q[sel] | out_ready[sel]);
    assign accept   = in_valid & in_ready;

    always_comb begin
        load  = 4'b0000;
        drain = full_q & out_ready;
        if (accept) begin
            load[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    full_q[i] <= 1'b1;
                    data_q[i] <= in_data;
                end else if (drain[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = full_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];

`ifdef DEMUX4_STREAM_CNT_EN
    logic [7:0] cnt_q [4];

    // Counts drains only; a pass-through cycle (drain+load) is one drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (drain[i]) begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// Directed self-checking bench for demux4_stream; drives inputs 1 time unit after
// each rising edge and checks outputs there, before the next edge.

module tb_demux4_stream;

    localparam int DATA_W = 8;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        sel;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [DATA_W-1:0] out_data0;
    logic [DATA_W-1:0] out_data1;
    logic [DATA_W-1:0] out_data2;
    logic [DATA_W-1:0] out_data3;
`ifdef DEMUX4_STREAM_CNT_EN
    logic [7:0]        cnt0;
    logic [7:0]        cnt1;
    logic [7:0]        cnt2;
    logic [7:0]        cnt3;
`endif

    int tests;
    int fails;

    demux4_stream #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3)
`ifdef DEMUX4_STREAM_CNT_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        sel       = 2'd0;
        out_ready = 4'b1111;

        // Reset state, input asserted but must not be accepted
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data0", 32'(out_data0), 32'h0);
        chk("rst_out_data3", 32'(out_data3), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        step();
        chk("rst_hold_valid", 32'(out_valid), 32'h0);
        in_valid = 1'b0;
        #5;
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'h1);

        // Single route to channel 2
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        sel       = 2'd2;
        step();
        in_valid = 1'b0;
        chk("route_valid", 32'(out_valid), 32'b0100);
        chk("route_data2", 32'(out_data2), 32'hA5);
        out_ready = 4'b0100;
        step();
        out_ready = 4'b0000;
        chk("route_drained", 32'(out_valid), 32'b0000);
        chk("route_data2_hold", 32'(out_data2), 32'hA5);

        // Backpressure on channel 1
        in_valid = 1'b1;
        sel      = 2'd1;
        in_data  = 8'h77;
        step();
        in_data = 8'h3C;
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready_low", 32'(in_ready), 32'h0);
            step();
        end
        chk("bp_data1_old", 32'(out_data1), 32'h77);
        out_ready = 4'b0010;
        #1;
        chk("bp_in_ready_high", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        chk("bp_data1_new", 32'(out_data1), 32'h3C);
        chk("bp_valid", 32'(out_valid), 32'b0010);
        step();
        out_ready = 4'b0000;
        chk("bp_drained", 32'(out_valid), 32'b0000);

        // Streaming pass-through on channel 0
        out_ready = 4'b1111;
        sel       = 2'd0;
        in_valid  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_data = 8'(k);
            #1;
            chk("stream_in_ready", 32'(in_ready), 32'h1);
            step();
            chk("stream_data0", 32'(out_data0), 32'(k));
            chk("stream_valid0", 32'(out_valid[0]), 32'h1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_valid", 32'(out_valid), 32'b0000);
        chk("stream_end_data0", 32'(out_data0), 32'h4);

        // Fan-out: fill all four, then release only channel 3
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sel     = 2'(k);
            in_data = 8'h10 + 8'(k);
            step();
        end
        in_valid = 1'b0;
        chk("fan_all_full", 32'(out_valid), 32'b1111);
        chk("fan_data0", 32'(out_data0), 32'h10);
        chk("fan_data1", 32'(out_data1), 32'h11);
        chk("fan_data2", 32'(out_data2), 32'h12);
        chk("fan_data3", 32'(out_data3), 32'h13);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk("fan_blocked", 32'(in_ready), 32'h0);
        end
        out_ready = 4'b1000;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk("fan_sel_ready", 32'(in_ready), (s == 3) ? 32'h1 : 32'h0);
        end
        step();
        chk("fan_drain3", 32'(out_valid), 32'b0111);
        chk("fan_data3_hold", 32'(out_data3), 32'h13);

        // Clear everything, then 300 drains on channel 0
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
`ifdef DEMUX4_STREAM_CNT_EN
        chk("cnt0_after_rst", 32'(cnt0), 32'h0);
`endif
        out_ready = 4'b0001;
        sel       = 2'd0;
        in_valid  = 1'b1;
        for (int k = 0; k < 300; k++) begin
            in_data = 8'(k);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("drain300_valid", 32'(out_valid), 32'b0000);
        chk("drain300_data0", 32'(out_data0), 32'(8'(299)));
`ifdef DEMUX4_STREAM_CNT_EN
        chk("cnt0_wrap", 32'(cnt0), 32'd44);
        chk("cnt1_idle", 32'(cnt1), 32'd0);
`endif

        // Reset mid-cycle with a beat held
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 8'h99;
        step();
        in_valid = 1'b0;
        chk("mid_loaded", 32'(out_valid), 32'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'b0000);
        chk("mid_rst_data0", 32'(out_data0), 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
`ifdef DEMUX4_STREAM_CNT_EN
        chk("mid_rst_cnt0", 32'(cnt0), 32'h0);
`endif
        #2;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        sel      = 2'd1;
        in_data  = 8'h5A;
        step();
        in_valid = 1'b0;
        chk("post_rst_accept", 32'(out_valid), 32'b0010);
        chk("post_rst_data1", 32'(out_data1), 32'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/demux4_stream.md
Name: demux4_stream

Overview:
- 1->4 stream demultiplexer. Routes each input beat to one of four output channels selected by a 2-bit `sel`.
- Each output has a one-entry holding register with valid/ready handshake.
- Forms the distribution side of the lab datapath. It fans a single producer out to four consumers, the inverse of the 4->1 selection stage.

Parameters:
- DATA_W, 8, width of data payload on input and every output.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts input beat this cycle.
- in_data  input  DATA_W  input payload.
- sel  input  2  destination channel index 0..3, qualified by in_valid.
- out_valid  output  4  bit i: channel i holding register full.
- out_ready  input  4  bit i: consumer i accepts this cycle.
- out_data0  output  DATA_W  channel 0 payload.
- out_data1  output  DATA_W  channel 1 payload.
- out_data2  output  DATA_W  channel 2 payload.
- out_data3  output  DATA_W  channel 3 payload.

Behaviour:
- Reset (rst_n low, async):
  - out_valid = 4'b0000.
  - out_data0..3 = 0.
  - Any held beats are discarded.
  - in_ready is low while rst_n is low.
- Per-channel state is one full flag plus one DATA_W register. No other FSM. Two states per channel:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on simultaneous drain+load.
- Handshake:
  - in_ready = rst_n & (~out_valid[sel] | out_ready[sel]). This is combinational from sel and out_ready; no registered path is required.
  - Accept = in_valid & in_ready. On accept, reg[sel] <= in_data and out_valid[sel] <= 1 at the next edge.
  - Drain of channel i = out_valid[i] & out_ready[i]. Without a same-cycle load to i, out_valid[i] <= 0 and out_data_i holds its last value.
- Latency: accepted beat visible on out_valid/out_data of channel sel exactly 1 cycle after accept.
- Throughput: 1 beat/cycle into any channel whose consumer keeps out_ready high (pass-through: drain and load in the same cycle).
- Independence:
  - Channels drain concurrently and independently.
  - A stalled channel blocks input only while sel points at it.
  - No reordering within a channel. No ordering guarantee across channels.
- Producer rule: in_data and sel stay stable while in_valid is high and in_ready is low. A violation is a producer error; the block samples only on accept.
- Boundary cases:
  - All four full, no out_ready: in_ready = 0 for every sel.
  - sel changes on a cycle without accept: in_ready re-evaluates against the new channel.
  - in_valid low: no state change except drains.
  - Reset asserted mid-transfer: beat is lost, outputs clear immediately. After release, the first accept is allowed on the first clk edge with rst_n high.

Optional Feature:
- Macro DEMUX4_STREAM_CNT_EN.
- With the macro: adds output ports cnt0..cnt3, each 8 bits.
  - cnt_i increments on each drain of channel i.
  - Wraps 255 -> 0.
  - Resets to 0.
  - Drain and load in the same cycle counts once.
- Without the macro: the ports and counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst_n=0 -> out_valid=0000, out_data*=0, in_ready=0. Release with out_ready=1111 -> in_ready=1.
- Single route: in_data=8'hA5, sel=2, in_valid for 1 cycle, out_ready=0000 -> next cycle out_valid=0100, out_data2=A5. Then out_ready[2]=1 for 1 cycle -> out_valid=0000.
- Backpressure: channel 1 full, out_ready[1]=0, sel=1, in_data=8'h3C held 5 cycles -> in_ready=0 all 5 cycles. Raise out_ready[1] -> accept same cycle; out_data1=3C next cycle.
- Streaming pass-through: out_ready=1111, sel=0 with data 1,2,3,4 on consecutive cycles -> in_ready stays 1; out_data0 shows 1,2,3,4 one cycle later, out_valid[0] continuously 1.
- Fan-out independence: fill channels 0..3 with 10,11,12,13, out_ready=0000 -> out_valid=1111, in_ready=0. Drain only channel 3 -> in_ready=1 only when sel=3.
- Reset mid-operation, DEMUX4_STREAM_CNT_EN defined: 300 drains on channel 0 -> cnt0=44. Assert rst_n=0 asynchronously mid-cycle -> out_valid=0000 and cnt0=0 before the next edge.
